match_score_ctrl: RTL and testbench

Sequencer for the two-player comparison scoring datapath. It requests operand pairs from an upstream source and compares each pair. Per round it updates player-A and player-B scores and a tie snapshot, using the same increment rules as the score logic. It ends a match after a fixed number of rounds or when a player reaches the winning score, and it reports the winner. It sits between the operand source (switch/LFSR front end) and the score display logic.

---
 rtl/match_score_ctrl.sv | 172 +++++++++++++++++
 tb/tb_match_score_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/match_score_ctrl.sv
// match_score_ctrl
//   Round sequencer for the two-player comparison scoring datapath.
//   It requests an operand pair, compares the pair, and then updates the
//   scores, the tie snapshot and the round count. A match ends after
//   ROUNDS rounds or as soon as either score reaches WIN_SCORE.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   start               begin a match (honoured only in IDLE or DONE)
//   op_valid            upstream operand pair valid
//   a_val, b_val        player operands, W bits
//   op_req              ready to accept an operand pair (FETCH)
//   comp_out            10 = A>B, 01 = B>A, 00 = equal
//   score_a, score_b    saturating player scores
//   tie_snap            score_a before the increment on the most recent tie
//   round_cnt           rounds completed in this match
//   winner              00 none, 10 A, 01 B, 11 draw
//   busy, done          FETCH/COMPARE/UPDATE, DONE
//   state_dbg           current FSM state encoding
//
// Handshake: a pair transfers on a rising edge where op_valid && op_req.
// The upstream source holds a_val/b_val stable until that edge, and
// op_valid is ignored whenever op_req is low.
module match_score_ctrl #(
   parameter int W         = 4,
   parameter int SCORE_W   = 4,
   parameter int ROUNDS    = 8,
   parameter int WIN_SCORE = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               op_valid,
   input  logic [W-1:0]       a_val,
   input  logic [W-1:0]       b_val,
   output logic               op_req,
   output logic [1:0]         comp_out,
   output logic [SCORE_W-1:0] score_a,
   output logic [SCORE_W-1:0] score_b,
   output logic [SCORE_W-1:0] tie_snap,
   output logic [SCORE_W-1:0] round_cnt,
   output logic [1:0]         winner,
   output logic               busy,
   output logic               done,
   output logic [2:0]         state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_COMPARE = 3'd2,
      S_UPDATE  = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [SCORE_W-1:0] WIN_C     = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] ROUNDS_C  = SCORE_W'(ROUNDS);
   localparam logic [SCORE_W-1:0] ONE       = SCORE_W'(1);

   state_t             state_q, state_d;
   logic [W-1:0]       a_lat_q, a_lat_d;
   logic [W-1:0]       b_lat_q, b_lat_d;
   logic [1:0]         comp_q, comp_d;
   logic [SCORE_W-1:0] score_a_q, score_a_d;
   logic [SCORE_W-1:0] score_b_q, score_b_d;
   logic [SCORE_W-1:0] tie_q, tie_d;
   logic [SCORE_W-1:0] round_q, round_d;
   logic [1:0]         winner_q, winner_d;
   logic [SCORE_W-1:0] a_inc, b_inc;

   // Saturating increments: a score at its maximum stays there.
   assign a_inc = (score_a_q == SCORE_MAX) ? score_a_q : score_a_q + ONE;
   assign b_inc = (score_b_q == SCORE_MAX) ? score_b_q : score_b_q + ONE;

   always_comb begin
      state_d   = state_q;
      a_lat_d   = a_lat_q;
      b_lat_d   = b_lat_q;
      comp_d    = comp_q;
      score_a_d = score_a_q;
      score_b_d = score_b_q;
      tie_d     = tie_q;
      round_d   = round_q;
      winner_d  = winner_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_FETCH;
               comp_d    = 2'b00;
               score_a_d = '0;
               score_b_d = '0;
               tie_d     = '0;
               round_d   = '0;
               winner_d  = 2'b00;
            end
         end
         S_FETCH: begin
            if (op_valid) begin
               a_lat_d = a_val;
               b_lat_d = b_val;
               state_d = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (a_lat_q > b_lat_q)      comp_d = 2'b10;
            else if (b_lat_q > a_lat_q) comp_d = 2'b01;
            else                        comp_d = 2'b00;
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
            case (comp_q)
               2'b10:   score_a_d = a_inc;
               2'b01:   score_b_d = b_inc;
               default: begin
                  tie_d     = score_a_q;
                  score_a_d = a_inc;
                  score_b_d = b_inc;
               end
            endcase
            round_d = round_q + ONE;
            // End check and winner use the post-update values.
            if (score_a_d >= WIN_C || score_b_d >= WIN_C || round_d == ROUNDS_C) begin
               state_d = S_DONE;
               if (score_a_d > score_b_d)      winner_d = 2'b10;
               else if (score_b_d > score_a_d) winner_d = 2'b01;
               else                            winner_d = 2'b11;
            end else begin
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         a_lat_q   <= '0;
         b_lat_q   <= '0;
         comp_q    <= 2'b00;
         score_a_q <= '0;
         score_b_q <= '0;
         tie_q     <= '0;
         round_q   <= '0;
         winner_q  <= 2'b00;
      end else begin
         state_q   <= state_d;
         a_lat_q   <= a_lat_d;
         b_lat_q   <= b_lat_d;
         comp_q    <= comp_d;
         score_a_q <= score_a_d;
         score_b_q <= score_b_d;
         tie_q     <= tie_d;
         round_q   <= round_d;
         winner_q  <= winner_d;
      end
   end

   assign op_req    = (state_q == S_FETCH);
   assign busy      = (state_q == S_FETCH) || (state_q == S_COMPARE) || (state_q == S_UPDATE);
   assign done      = (state_q == S_DONE);
   assign comp_out  = comp_q;
   assign score_a   = score_a_q;
   assign score_b   = score_b_q;
   assign tie_snap  = tie_q;
   assign round_cnt = round_q;
   assign winner    = winner_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_match_score_ctrl.sv
// tb_match_score_ctrl
//   Directed bench for match_score_ctrl. Three instances share the input
//   stimulus: u_r3 (ROUNDS=3, WIN_SCORE=5), u_df (ROUNDS=8, WIN_SCORE=5)
//   and u_w2 (ROUNDS=8, WIN_SCORE=2). Each scenario task checks the
//   instance whose parameters it targets.
module tb_match_score_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       op_valid = 1'b0;
   logic [3:0] a_val = '0;
   logic [3:0] b_val = '0;

   logic       r3_op_req, df_op_req, w2_op_req;
   logic [1:0] r3_comp, df_comp, w2_comp;
   logic [3:0] r3_sa, df_sa, w2_sa;
   logic [3:0] r3_sb, df_sb, w2_sb;
   logic [3:0] r3_tie, df_tie, w2_tie;
   logic [3:0] r3_rc, df_rc, w2_rc;
   logic [1:0] r3_win, df_win, w2_win;
   logic       r3_busy, df_busy, w2_busy;
   logic       r3_done, df_done, w2_done;
   logic [2:0] r3_st, df_st, w2_st;

   int chk_n = 0;
   int err_n = 0;

   always #5 clk = ~clk;

   match_score_ctrl #(.W(4), .SCORE_W(4), .ROUNDS(3), .WIN_SCORE(5)) u_r3 (
      .clk(clk), .reset(reset), .start(start), .op_valid(op_valid),
      .a_val(a_val), .b_val(b_val), .op_req(r3_op_req), .comp_out(r3_comp),
      .score_a(r3_sa), .score_b(r3_sb), .tie_snap(r3_tie), .round_cnt(r3_rc),
      .winner(r3_win), .busy(r3_busy), .done(r3_done), .state_dbg(r3_st));

   match_score_ctrl #(.W(4), .SCORE_W(4), .ROUNDS(8), .WIN_SCORE(5)) u_df (
      .clk(clk), .reset(reset), .start(start), .op_valid(op_valid),
      .a_val(a_val), .b_val(b_val), .op_req(df_op_req), .comp_out(df_comp),
      .score_a(df_sa), .score_b(df_sb), .tie_snap(df_tie), .round_cnt(df_rc),
      .winner(df_win), .busy(df_busy), .done(df_done), .state_dbg(df_st));

   match_score_ctrl #(.W(4), .SCORE_W(4), .ROUNDS(8), .WIN_SCORE(2)) u_w2 (
      .clk(clk), .reset(reset), .start(start), .op_valid(op_valid),
      .a_val(a_val), .b_val(b_val), .op_req(w2_op_req), .comp_out(w2_comp),
      .score_a(w2_sa), .score_b(w2_sb), .tie_snap(w2_tie), .round_cnt(w2_rc),
      .winner(w2_win), .busy(w2_busy), .done(w2_done), .state_dbg(w2_st));

   // Advance one edge and settle; outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1; start = 1'b0; op_valid = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic start_match();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // One round with op_valid high from a FETCH state: E0, E1, E2.
   task automatic drive_round(input logic [3:0] a, input logic [3:0] b);
      a_val = a; b_val = b; op_valid = 1'b1;
      tick(); tick(); tick();
   endtask

   task automatic test_reset();
      apply_reset();
      chk_n++; if (df_op_req !== 1'b0) begin err_n++; $display("FAIL reset_op_req got %0h exp 0", df_op_req); end
      chk_n++; if (df_busy !== 1'b0) begin err_n++; $display("FAIL reset_busy got %0h exp 0", df_busy); end
      chk_n++; if (df_done !== 1'b0) begin err_n++; $display("FAIL reset_done got %0h exp 0", df_done); end
      chk_n++; if ({df_comp, df_win} !== 4'h0) begin err_n++; $display("FAIL reset_comp_win got %0h exp 0", {df_comp, df_win}); end
      chk_n++; if ({df_sa, df_sb, df_tie, df_rc} !== 16'h0) begin err_n++; $display("FAIL reset_counters got %0h exp 0", {df_sa, df_sb, df_tie, df_rc}); end
      chk_n++; if (df_st !== 3'd0) begin err_n++; $display("FAIL reset_state got %0d exp 0", df_st); end
      chk_n++; if ({r3_op_req, r3_done, r3_sa, w2_op_req, w2_done, w2_sa} !== 12'h0) begin err_n++; $display("FAIL reset_other_inst got %0h exp 0", {r3_op_req, r3_done, r3_sa, w2_op_req, w2_done, w2_sa}); end
   endtask

   task automatic test_three_rounds();
      logic [3:0] pa [3];
      logic [3:0] pb [3];
      logic [1:0] pc [3];
      pa = '{4'd9, 4'd2, 4'd5};
      pb = '{4'd3, 4'd7, 4'd5};
      pc = '{2'b10, 2'b01, 2'b00};
      apply_reset();
      start_match();
      chk_n++; if (r3_op_req !== 1'b1) begin err_n++; $display("FAIL t1_op_req_after_start got %0h exp 1", r3_op_req); end
      for (int i = 0; i < 3; i++) begin
         a_val = pa[i]; b_val = pb[i]; op_valid = 1'b1;
         tick();
         chk_n++; if ({r3_op_req, r3_busy} !== 2'b01) begin err_n++; $display("FAIL t1_after_e0 r%0d got %0b exp 01", i, {r3_op_req, r3_busy}); end
         tick();
         chk_n++; if (r3_comp !== pc[i]) begin err_n++; $display("FAIL t1_comp r%0d got %0b exp %0b", i, r3_comp, pc[i]); end
         tick();
         chk_n++; if (r3_rc !== 4'(i + 1)) begin err_n++; $display("FAIL t1_round r%0d got %0d exp %0d", i, r3_rc, i + 1); end
         if (i < 2) begin
            chk_n++; if (r3_op_req !== 1'b1) begin err_n++; $display("FAIL t1_3cycle r%0d op_req got %0h exp 1", i, r3_op_req); end
         end
      end
      chk_n++; if (r3_done !== 1'b1) begin err_n++; $display("FAIL t1_done got %0h exp 1", r3_done); end
      chk_n++; if ({r3_sa, r3_sb} !== 8'h22) begin err_n++; $display("FAIL t1_scores got %0h exp 22", {r3_sa, r3_sb}); end
      chk_n++; if (r3_tie !== 4'd1) begin err_n++; $display("FAIL t1_tie_snap got %0d exp 1", r3_tie); end
      chk_n++; if (r3_win !== 2'b11) begin err_n++; $display("FAIL t1_winner got %0b exp 11", r3_win); end
      op_valid = 1'b0;
   endtask

   task automatic test_a_sweep();
      apply_reset();
      start_match();
      for (int i = 0; i < 5; i++) begin
         drive_round(4'd15, 4'd0);
         if (i < 4) begin
            chk_n++; if ({df_op_req, df_sa} !== {1'b1, 4'(i + 1)}) begin err_n++; $display("FAIL t2_round%0d got %0h exp %0h", i, {df_op_req, df_sa}, {1'b1, 4'(i + 1)}); end
         end
      end
      chk_n++; if (df_done !== 1'b1) begin err_n++; $display("FAIL t2_done got %0h exp 1", df_done); end
      chk_n++; if ({df_sa, df_sb, df_rc} !== 12'h505) begin err_n++; $display("FAIL t2_results got %0h exp 505", {df_sa, df_sb, df_rc}); end
      chk_n++; if (df_win !== 2'b10) begin err_n++; $display("FAIL t2_winner got %0b exp 10", df_win); end
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_n++; if ({df_op_req, df_done, df_sa} !== 6'b01_0101) begin err_n++; $display("FAIL t2_hold c%0d got %0b exp 010101", i, {df_op_req, df_done, df_sa}); end
      end
      op_valid = 1'b0;
   endtask

   task automatic test_stall();
      apply_reset();
      start_match();
      op_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_val = 4'(i * 3 + 1); b_val = 4'd8;
         tick();
         chk_n++; if ({df_op_req, df_busy, df_rc, df_sa, df_sb} !== {2'b11, 12'h000}) begin err_n++; $display("FAIL t3_stall c%0d got %0h exp 3000", i, {df_op_req, df_busy, df_rc, df_sa, df_sb}); end
      end
      a_val = 4'd3; op_valid = 1'b1;
      tick(); tick();
      chk_n++; if (df_comp !== 2'b01) begin err_n++; $display("FAIL t3_comp got %0b exp 01", df_comp); end
      tick();
      chk_n++; if ({df_sa, df_sb, df_rc} !== 12'h011) begin err_n++; $display("FAIL t3_scores got %0h exp 011", {df_sa, df_sb, df_rc}); end
      op_valid = 1'b0;
   endtask

   task automatic test_tie_win();
      apply_reset();
      start_match();
      drive_round(4'd4, 4'd4);
      chk_n++; if ({w2_op_req, w2_sa, w2_sb, w2_tie} !== {1'b1, 12'h110}) begin err_n++; $display("FAIL t4_round1 got %0h exp 1110", {w2_op_req, w2_sa, w2_sb, w2_tie}); end
      drive_round(4'd6, 4'd6);
      chk_n++; if (w2_done !== 1'b1) begin err_n++; $display("FAIL t4_done got %0h exp 1", w2_done); end
      chk_n++; if ({w2_sa, w2_sb, w2_tie, w2_rc} !== 16'h2212) begin err_n++; $display("FAIL t4_results got %0h exp 2212", {w2_sa, w2_sb, w2_tie, w2_rc}); end
      chk_n++; if (w2_win !== 2'b11) begin err_n++; $display("FAIL t4_winner got %0b exp 11", w2_win); end
      op_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      start_match();
      drive_round(4'd9, 4'd3);
      a_val = 4'd1; b_val = 4'd2;
      tick();
      chk_n++; if (df_st !== 3'd2) begin err_n++; $display("FAIL t5_in_compare got %0d exp 2", df_st); end
      reset = 1'b1;
      tick();
      reset = 1'b0; op_valid = 1'b0;
      chk_n++; if ({df_op_req, df_busy, df_done, df_comp, df_win, df_st} !== 10'h0) begin err_n++; $display("FAIL t5_ctrl_cleared got %0h exp 0", {df_op_req, df_busy, df_done, df_comp, df_win, df_st}); end
      chk_n++; if ({df_sa, df_sb, df_tie, df_rc} !== 16'h0) begin err_n++; $display("FAIL t5_counters_cleared got %0h exp 0", {df_sa, df_sb, df_tie, df_rc}); end
      tick();
      chk_n++; if (df_op_req !== 1'b0) begin err_n++; $display("FAIL t5_stays_idle got %0h exp 0", df_op_req); end
      reset = 1'b1; start = 1'b1;
      tick();
      reset = 1'b0; start = 1'b0;
      chk_n++; if ({df_op_req, df_st} !== 4'h0) begin err_n++; $display("FAIL t5_reset_beats_start got %0h exp 0", {df_op_req, df_st}); end
      start_match();
      chk_n++; if (df_op_req !== 1'b1) begin err_n++; $display("FAIL t5_restart_op_req got %0h exp 1", df_op_req); end
      drive_round(4'd0, 4'd5);
      chk_n++; if ({df_comp, df_sa, df_sb, df_rc} !== {2'b01, 12'h011}) begin err_n++; $display("FAIL t5_clean_round got %0h exp %0h", {df_comp, df_sa, df_sb, df_rc}, {2'b01, 12'h011}); end
      op_valid = 1'b0;
   endtask

   task automatic test_start_ignored();
      apply_reset();
      start_match();
      drive_round(4'd9, 4'd3);
      op_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk_n++; if ({r3_op_req, r3_sa, r3_rc} !== {1'b1, 8'h11}) begin err_n++; $display("FAIL t6_start_in_fetch got %0h exp 111", {r3_op_req, r3_sa, r3_rc}); end
      a_val = 4'd8; b_val = 4'd2; op_valid = 1'b1;
      tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk_n++; if ({r3_op_req, r3_sa, r3_rc} !== {1'b1, 8'h22}) begin err_n++; $display("FAIL t6_start_in_update got %0h exp 122", {r3_op_req, r3_sa, r3_rc}); end
      drive_round(4'd7, 4'd1);
      op_valid = 1'b0;
      chk_n++; if ({r3_done, r3_sa, r3_win} !== {1'b1, 4'd3, 2'b10}) begin err_n++; $display("FAIL t6_match_done got %0h exp %0h", {r3_done, r3_sa, r3_win}, {1'b1, 4'd3, 2'b10}); end
      start_match();
      chk_n++; if ({r3_done, r3_op_req} !== 2'b01) begin err_n++; $display("FAIL t6_restart_flags got %0b exp 01", {r3_done, r3_op_req}); end
      chk_n++; if ({r3_sa, r3_sb, r3_rc, r3_win, r3_comp} !== 16'h0) begin err_n++; $display("FAIL t6_restart_cleared got %0h exp 0", {r3_sa, r3_sb, r3_rc, r3_win, r3_comp}); end
   endtask

   initial begin
      test_reset();
      test_three_rounds();
      test_a_sweep();
      test_stall();
      test_tie_win();
      test_reset_mid();
      test_start_ignored();
      $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
      $finish;
   end

endmodule
